// File: rtl/uart_tx_pkg.sv
// Shared constants, state encoding and helpers for the memory-mapped UART transmitter.
package uart_tx_pkg;

   localparam int MEM_ADDR_BUS = 32;
   localparam int MEM_BUS      = 32;

   // Register word indices, i.e. byte offset >> 2 (0x0, 0x4, 0x8, 0xC)
   localparam logic [1:0] UART_CTRL   = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;
   localparam logic [1:0] UART_TXDATA = 2'd2;
   localparam logic [1:0] UART_BAUD   = 2'd3;

   localparam logic [15:0] UART_DIV_MIN = 16'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < UART_DIV_MIN) ? UART_DIV_MIN : v;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Bus slave port of the UART transmitter: write strobe, address, write data, read data.
interface uart_tx_if;
   import uart_tx_pkg::*;

   logic                    we_i;
   logic [MEM_ADDR_BUS-1:0] addr_i;
   logic [MEM_BUS-1:0]      wdata_i;
   logic [MEM_BUS-1:0]      rdata_o;

   modport master (output we_i, output addr_i, output wdata_i, input rdata_o);
   modport slave  (input we_i, input addr_i, input wdata_i, output rdata_o);

endinterface

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign level   = cnt_q;
   assign rdata   = mem_q[rd_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) begin
         mem_d[wr_q] = wdata;
         wr_d        = wr_q + AW'(1);
      end
      if (do_pop) rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud timer and frame FSM.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_IDLE  | line high, waiting for tx_en and queued data
//   ST_START | start bit (line low) for one period
//   ST_DATA  | 8 data bits, LSB first, one period each
//   ST_STOP  | stop bit (line high); may pop straight into START
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic      clk,
   input  logic      rst,
   uart_tx_if.slave  bus,
   output logic      tx_o,
   output logic      irq_o
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]  ctrl_q, ctrl_d;
   logic        ovf_q, ovf_d;
   logic [15:0] baud_q, baud_d;
   tx_state_t   state_q, state_d;
   logic [15:0] period_q, period_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;

   logic          push_req, pop, start_frame, tc, busy;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_head;
   logic [LW-1:0] fifo_level;
   logic [1:0]    sel;
   logic          unused_bits;

   assign sel         = bus.addr_i[3:2];
   assign push_req    = bus.we_i && (sel == UART_TXDATA);
   assign busy        = (state_q != ST_IDLE);
   assign tc          = (cnt_q == 16'd0);
   assign tx_o        = tx_q;
   assign irq_o       = ctrl_q[1] && fifo_empty && !busy;
   assign unused_bits = ^{bus.addr_i[MEM_ADDR_BUS-1:4], bus.addr_i[1:0],
                          bus.wdata_i[MEM_BUS-1:16]};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop),
      .wdata (bus.wdata_i[7:0]),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      ctrl_d = ctrl_q;
      ovf_d  = ovf_q;
      baud_d = baud_q;
      if (bus.we_i) begin
         case (sel)
            UART_CTRL:   ctrl_d = bus.wdata_i[1:0];
            UART_STATUS: if (bus.wdata_i[3]) ovf_d = 1'b0;
            UART_BAUD:   baud_d = clamp_div(bus.wdata_i[15:0]);
            default:     ;
         endcase
      end
      // A simultaneous pop frees the slot, so that push is not an overflow
      if (push_req && fifo_full && !pop) ovf_d = 1'b1;
   end

   always_comb begin
      bus.rdata_o = '0;
      case (sel)
         UART_CTRL:   bus.rdata_o[1:0]  = ctrl_q;
         UART_STATUS: bus.rdata_o[8:0]  = {5'(fifo_level), ovf_q, fifo_empty, fifo_full, busy};
         UART_BAUD:   bus.rdata_o[15:0] = baud_q;
         default:     ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      start_frame = 1'b0;
      case (state_q)
         ST_IDLE: start_frame = ctrl_q[0] && !fifo_empty;
         ST_START: begin
            if (tc) begin
               state_d = ST_DATA;
               cnt_d   = period_q - 16'd1;
               bit_d   = 3'd0;
            end else cnt_d = cnt_q - 16'd1;
         end
         ST_DATA: begin
            if (tc) begin
               cnt_d   = period_q - 16'd1;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) state_d = ST_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else cnt_d = cnt_q - 16'd1;
         end
         ST_STOP: begin
            if (tc) begin
               start_frame = ctrl_q[0] && !fifo_empty;
               state_d     = ST_IDLE;
            end else cnt_d = cnt_q - 16'd1;
         end
      endcase
      // Period is latched per frame so BAUD writes never disturb a frame in flight
      if (start_frame) begin
         state_d  = ST_START;
         period_d = baud_q;
         cnt_d    = baud_q - 16'd1;
         shift_d  = fifo_head;
      end
      pop = start_frame;
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q   <= 2'b00;
         ovf_q    <= 1'b0;
         baud_q   <= DIV_RESET;
         state_q  <= ST_IDLE;
         period_q <= DIV_RESET;
         cnt_q    <= 16'd0;
         bit_q    <= 3'd0;
         shift_q  <= 8'd0;
         tx_q     <= 1'b1;
      end else begin
         ctrl_q   <= ctrl_d;
         ovf_q    <= ovf_d;
         baud_q   <= baud_d;
         state_q  <= state_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: reset, single frame, overflow, back-to-back, BAUD change, reset mid-frame.
module tb_uart_tx;

   logic clk;
   logic rst;
   logic tx_o;
   logic irq_o;
   int   checks;
   int   errors;

   uart_tx_if bus ();

   uart_tx #(.FIFO_DEPTH(4), .DIV_RESET(16'd434)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .tx_o  (tx_o),
      .irq_o (irq_o)
   );

   always #5 clk = ~clk;

   // Presents a write before the next rising edge; returns 1 ns after that edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.we_i    = 1'b1;
      bus.addr_i  = a;
      bus.wdata_i = d;
      @(posedge clk);
      #1;
      bus.we_i    = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      bus.addr_i = a;
      #1;
      d = bus.rdata_o;
   endtask

   task automatic test_reset;
      logic [31:0] rd;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx_in_rst: got %b want 1", tx_o); end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_o); end
      checks++;
      if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_o); end
      bus_read(32'h4, rd);
      checks++;
      if (rd !== 32'h4) begin errors++; $display("FAIL reset_status: got %h want 00000004", rd); end
      bus_read(32'hC, rd);
      checks++;
      if (rd !== 32'd434) begin errors++; $display("FAIL reset_baud: got %0d want 434", rd); end
      bus_read(32'h0, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", rd); end
      bus_read(32'h8, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_txdata_read: got %h want 0", rd); end
   endtask

   task automatic test_single_frame;
      logic [31:0] rd;
      logic [9:0]  frame;
      int          busy_cycles;
      bus_write(32'hC, 32'd1);
      bus_read(32'hC, rd);
      checks++;
      if (rd !== 32'd2) begin errors++; $display("FAIL baud_clamp: got %0d want 2", rd); end
      bus_write(32'hC, 32'd4);
      bus_read(32'hC, rd);
      checks++;
      if (rd !== 32'd4) begin errors++; $display("FAIL baud_write: got %0d want 4", rd); end
      bus_write(32'h0, 32'h1);
      bus_write(32'h8, 32'h55);
      bus_read(32'h4, rd);
      checks++;
      if (rd !== 32'h10) begin errors++; $display("FAIL single_status_after_push: got %h want 00000010", rd); end
      frame = {1'b1, 8'h55, 1'b0};
      busy_cycles = 0;
      bus.addr_i = 32'h4;
      @(posedge clk);
      #1;
      for (int k = 0; k < 44; k++) begin
         checks++;
         if (k < 40) begin
            if (tx_o !== frame[k/4]) begin
               errors++;
               $display("FAIL single_tx cycle %0d: got %b want %b", k, tx_o, frame[k/4]);
            end
         end else if (tx_o !== 1'b1) begin
            errors++;
            $display("FAIL single_tx_idle cycle %0d: got %b want 1", k, tx_o);
         end
         if (bus.rdata_o[0] === 1'b1) busy_cycles++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (busy_cycles != 40) begin errors++; $display("FAIL single_busy_len: got %0d want 40", busy_cycles); end
   endtask

   task automatic test_overflow;
      logic [31:0] rd;
      logic [7:0]  bytes [5];
      bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      bus_write(32'h0, 32'h0);
      for (int i = 0; i < 4; i++) bus_write(32'h8, {24'h0, bytes[i]});
      bus_read(32'h4, rd);
      checks++;
      if (rd !== 32'h42) begin errors++; $display("FAIL ovf_full4: got %h want 00000042", rd); end
      bus_write(32'h8, {24'h0, bytes[4]});
      bus_read(32'h4, rd);
      checks++;
      if (rd !== 32'h4A) begin errors++; $display("FAIL ovf_set: got %h want 0000004a", rd); end
      bus_write(32'h4, 32'hFFFF_FFF7);
      bus_read(32'h4, rd);
      checks++;
      if (rd !== 32'h4A) begin errors++; $display("FAIL status_ro_write: got %h want 0000004a", rd); end
      bus_write(32'h4, 32'h8);
      bus_read(32'h4, rd);
      checks++;
      if (rd !== 32'h42) begin errors++; $display("FAIL ovf_clear: got %h want 00000042", rd); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd;
      logic [7:0]  bytes [4];
      logic [7:0]  b;
      logic        exp;
      int          slot;
      bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      bus_write(32'h0, 32'h1);
      bus_read(32'h4, rd);
      checks++;
      if (rd !== 32'h42) begin errors++; $display("FAIL b2b_before_pop: got %h want 00000042", rd); end
      bus.addr_i = 32'h4;
      @(posedge clk);
      #1;
      for (int k = 0; k < 160; k++) begin
         b    = bytes[k/40];
         slot = (k % 40) / 4;
         if (slot == 0)      exp = 1'b0;
         else if (slot == 9) exp = 1'b1;
         else                exp = b[slot-1];
         checks++;
         if (tx_o !== exp) begin
            errors++;
            $display("FAIL b2b_tx cycle %0d: got %b want %b", k, tx_o, exp);
         end
         checks++;
         if (bus.rdata_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy cycle %0d: got %b want 1", k, bus.rdata_o[0]);
         end
         @(posedge clk);
         #1;
      end
      bus_read(32'h4, rd);
      checks++;
      if (rd !== 32'h4) begin errors++; $display("FAIL b2b_done_status: got %h want 00000004", rd); end
      checks++;
      if (tx_o !== 1'b1) begin errors++; $display("FAIL b2b_done_tx: got %b want 1", tx_o); end
   endtask

   task automatic test_baud_midframe;
      logic [31:0] rd;
      logic [9:0]  frame;
      bus_write(32'h0, 32'h3);
      checks++;
      if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_idle_empty: got %b want 1", irq_o); end
      bus_write(32'h8, 32'h3C);
      checks++;
      if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_queued: got %b want 0", irq_o); end
      frame = {1'b1, 8'h3C, 1'b0};
      @(posedge clk);
      #1;
      for (int k = 0; k < 40; k++) begin
         checks++;
         if (tx_o !== frame[k/4]) begin
            errors++;
            $display("FAIL baudchg_tx cycle %0d: got %b want %b", k, tx_o, frame[k/4]);
         end
         checks++;
         if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL baudchg_irq cycle %0d: got %b want 0", k, irq_o);
         end
         if (k == 12) begin
            bus.we_i    = 1'b1;
            bus.addr_i  = 32'hC;
            bus.wdata_i = 32'd8;
         end else begin
            bus.we_i = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (irq_o !== 1'b1) begin errors++; $display("FAIL baudchg_irq_end: got %b want 1", irq_o); end
      checks++;
      if (tx_o !== 1'b1) begin errors++; $display("FAIL baudchg_tx_end: got %b want 1", tx_o); end
      bus_read(32'hC, rd);
      checks++;
      if (rd !== 32'd8) begin errors++; $display("FAIL baudchg_readback: got %0d want 8", rd); end
   endtask

   task automatic test_reset_midframe;
      logic [31:0] rd;
      logic [9:0]  frame;
      int          low_cycles;
      bus_write(32'h8, 32'h01);
      frame = {1'b1, 8'h01, 1'b0};
      @(posedge clk);
      #1;
      for (int k = 0; k < 28; k++) begin
         checks++;
         if (tx_o !== frame[k/8]) begin
            errors++;
            $display("FAIL newbaud_tx cycle %0d: got %b want %b", k, tx_o, frame[k/8]);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (tx_o !== 1'b0) begin errors++; $display("FAIL pre_rst_tx: got %b want 0", tx_o); end
      rst = 1'b1;
      #1;
      checks++;
      if (tx_o !== 1'b1) begin errors++; $display("FAIL rst_async_tx: got %b want 1", tx_o); end
      checks++;
      if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_async_irq: got %b want 0", irq_o); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus_read(32'h4, rd);
      checks++;
      if (rd !== 32'h4) begin errors++; $display("FAIL post_rst_status: got %h want 00000004", rd); end
      bus_read(32'hC, rd);
      checks++;
      if (rd !== 32'd434) begin errors++; $display("FAIL post_rst_baud: got %0d want 434", rd); end
      bus_read(32'h0, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL post_rst_ctrl: got %h want 0", rd); end
      low_cycles = 0;
      for (int k = 0; k < 100; k++) begin
         if (tx_o !== 1'b1) low_cycles++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (low_cycles != 0) begin errors++; $display("FAIL post_rst_no_frame: got %0d low cycles want 0", low_cycles); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clk         = 1'b0;
      rst         = 1'b1;
      checks      = 0;
      errors      = 0;
      bus.we_i    = 1'b0;
      bus.addr_i  = '0;
      bus.wdata_i = '0;
      test_reset();
      test_single_frame();
      test_overflow();
      test_back_to_back();
      test_baud_midframe();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
